// File: rtl/sprite_compositor.sv
// Sprite compositor: three-stage pipeline that overlays up to NUM_SPR
// hardware sprites on a background pixel stream and tracks per-frame
// collisions against sprite 0.
//   S0: hit test + ROM address (registered spr_addr)
//   S1: external ROM fetch, side-band flags delayed alongside
//   S2: priority mux, blanking, collision update (registered outputs)
module sprite_compositor #(
   parameter int NUM_SPR   = 8,
   parameter int SPR_W     = 32,
   parameter int SPR_H     = 32,
   parameter int COLOR_W   = 9,
   parameter int H_DISPLAY = 640,
   parameter int V_DISPLAY = 480
) (
   input  logic                                  CLK,
   input  logic                                  RST_N,
   input  logic [9:0]                            h_count,
   input  logic [9:0]                            v_count,
   input  logic [10*NUM_SPR-1:0]                 spr_x,
   input  logic [10*NUM_SPR-1:0]                 spr_y,
   input  logic [NUM_SPR-1:0]                    spr_en,
   input  logic [NUM_SPR-1:0]                    spr_mirror,
   input  logic [COLOR_W-1:0]                    bg_color,
   output logic [$clog2(SPR_W*SPR_H)*NUM_SPR-1:0] spr_addr,
   input  logic [COLOR_W*NUM_SPR-1:0]            spr_data,
   output logic [COLOR_W-1:0]                    pixel,
   output logic                                  pixel_active,
   output logic [NUM_SPR-1:0]                    coll_mask,
   output logic                                  frame_start
);

   localparam int unsigned ADDR_W = $clog2(SPR_W * SPR_H);
   localparam int unsigned COL_W  = $clog2(SPR_W);
   localparam int unsigned ROW_W  = $clog2(SPR_H);

   // S0 combinational results
   logic [NUM_SPR-1:0]        hit_c;
   logic [ADDR_W*NUM_SPR-1:0] addr_c;
   logic                      act_c;
   logic                      first_c;

   // Pipeline side-band registers (q1 = after S0, q2 = aligned with ROM data)
   logic [NUM_SPR-1:0]        hit_q1, hit_q2;
   logic                      act_q1, act_q2;
   logic                      first_q1, first_q2;
   logic [COLOR_W-1:0]        bg_q1, bg_q2;

   // S2 combinational results
   logic [NUM_SPR-1:0]        opaque_c;
   logic [NUM_SPR-1:0]        coll_set_c;
   logic [COLOR_W-1:0]        pix_c;

   assign act_c   = ({1'b0, h_count} < 11'(H_DISPLAY)) && ({1'b0, v_count} < 11'(V_DISPLAY));
   assign first_c = (h_count == 10'd0) && (v_count == 10'd0);

   // Per-sprite hit test (11-bit bounds, no wrap) and ROM address generation
   for (genvar g = 0; g < NUM_SPR; g++) begin : g_spr
      logic [9:0]       x, y;
      logic [COL_W-1:0] col_raw, col;
      logic [ROW_W-1:0] row;

      assign x       = spr_x[10*g +: 10];
      assign y       = spr_y[10*g +: 10];
      assign col_raw = h_count[COL_W-1:0] - x[COL_W-1:0];
      assign col     = spr_mirror[g] ? ~col_raw : col_raw;
      assign row     = v_count[ROW_W-1:0] - y[ROW_W-1:0];

      assign hit_c[g] = spr_en[g]
                     && ({1'b0, h_count} >= {1'b0, x})
                     && ({1'b0, h_count} <  ({1'b0, x} + 11'(SPR_W)))
                     && ({1'b0, v_count} >= {1'b0, y})
                     && ({1'b0, v_count} <  ({1'b0, y} + 11'(SPR_H)));

      assign addr_c[ADDR_W*g +: ADDR_W] = {row, col};

      assign opaque_c[g] = hit_q2[g] && (|spr_data[COLOR_W*g +: COLOR_W]);
   end

   // ROM address register: only hitting sprites update, others hold
   always_ff @(posedge CLK) begin
      if (!RST_N) begin
         spr_addr <= '0;
      end else begin
         for (int i = 0; i < NUM_SPR; i++) begin
            if (hit_c[i]) begin
               spr_addr[ADDR_W*i +: ADDR_W] <= addr_c[ADDR_W*i +: ADDR_W];
            end
         end
      end
   end

   // Side-band delay line keeping flags aligned with the ROM read latency
   always_ff @(posedge CLK) begin
      if (!RST_N) begin
         hit_q1   <= '0;
         hit_q2   <= '0;
         act_q1   <= 1'b0;
         act_q2   <= 1'b0;
         first_q1 <= 1'b0;
         first_q2 <= 1'b0;
         bg_q1    <= '0;
         bg_q2    <= '0;
      end else begin
         hit_q1   <= hit_c;
         hit_q2   <= hit_q1;
         act_q1   <= act_c;
         act_q2   <= act_q1;
         first_q1 <= first_c;
         first_q2 <= first_q1;
         bg_q1    <= bg_color;
         bg_q2    <= bg_q1;
      end
   end

   // Priority mux (lowest opaque index wins) with blanking outside active area
   always_comb begin
      pix_c = bg_q2;
      for (int i = NUM_SPR - 1; i >= 0; i--) begin
         if (opaque_c[i]) begin
            pix_c = spr_data[COLOR_W*i +: COLOR_W];
         end
      end
      if (!act_q2) begin
         pix_c = '0;
      end
   end

   // Collisions of sprite i against sprite 0 on an active pixel
   always_comb begin
      coll_set_c = '0;
      for (int i = 1; i < NUM_SPR; i++) begin
         coll_set_c[i] = act_q2 && opaque_c[0] && opaque_c[i];
      end
   end

   // Output stage; collision bits clear at frame start but a same-pixel set wins
   always_ff @(posedge CLK) begin
      if (!RST_N) begin
         pixel        <= '0;
         pixel_active <= 1'b0;
         frame_start  <= 1'b0;
         coll_mask    <= '0;
      end else begin
         pixel        <= pix_c;
         pixel_active <= act_q2;
         frame_start  <= first_q2;
         coll_mask    <= (first_q2 ? '0 : coll_mask) | coll_set_c;
      end
   end

endmodule

// File: tb/tb_sprite_compositor.sv
// Scoreboard bench for sprite_compositor: stimulus pushes hand-computed
// expectations tagged with the cycle they are due; a monitor compares them.
module tb_sprite_compositor;

   localparam int NS = 8;

   logic          CLK;
   logic          RST_N;
   logic [9:0]    h_count, v_count;
   logic [79:0]   spr_x, spr_y;
   logic [7:0]    spr_en, spr_mirror;
   logic [8:0]    bg_color;
   logic [79:0]   spr_addr;
   logic [71:0]   spr_data;
   logic [8:0]    pixel;
   logic          pixel_active;
   logic [7:0]    coll_mask;
   logic          frame_start;

   logic [8:0]    rom_val [NS];
   int unsigned   cyc;
   int            checks;
   int            errors;

   typedef struct {
      int unsigned due;
      bit          kind;   // 0 = pixel outputs, 1 = ROM address
      int          idx;
      logic [8:0]  pix;
      logic        act;
      logic        fs;
      logic [7:0]  coll;
      logic [9:0]  addr;
      string       name;
   } exp_t;

   exp_t sb[$];

   sprite_compositor dut (
      .CLK(CLK), .RST_N(RST_N), .h_count(h_count), .v_count(v_count),
      .spr_x(spr_x), .spr_y(spr_y), .spr_en(spr_en), .spr_mirror(spr_mirror),
      .bg_color(bg_color), .spr_addr(spr_addr), .spr_data(spr_data),
      .pixel(pixel), .pixel_active(pixel_active), .coll_mask(coll_mask),
      .frame_start(frame_start)
   );

   initial begin
      CLK = 1'b0;
      forever #5 CLK = ~CLK;
   end

   initial cyc = 0;
   always @(posedge CLK) cyc <= cyc + 1;

   // Sprite ROMs: one-cycle read latency, constant content per sprite
   always @(posedge CLK) begin
      for (int i = 0; i < NS; i++) spr_data[9*i +: 9] <= rom_val[i];
   end

   // Monitor: compare every expectation on its due cycle, away from the edge
   always @(posedge CLK) begin
      #1;
      for (int k = sb.size() - 1; k >= 0; k--) begin
         if (sb[k].due == cyc) begin
            checks++;
            if (sb[k].kind == 1'b0) begin
               if (pixel !== sb[k].pix || pixel_active !== sb[k].act ||
                   frame_start !== sb[k].fs || coll_mask !== sb[k].coll) begin
                  errors++;
                  $display("FAIL %s: got pix=%h act=%b fs=%b coll=%b want pix=%h act=%b fs=%b coll=%b",
                           sb[k].name, pixel, pixel_active, frame_start, coll_mask,
                           sb[k].pix, sb[k].act, sb[k].fs, sb[k].coll);
               end
            end else begin
               if (spr_addr[10*sb[k].idx +: 10] !== sb[k].addr) begin
                  errors++;
                  $display("FAIL %s: got spr_addr%0d=%0d want %0d", sb[k].name, sb[k].idx,
                           spr_addr[10*sb[k].idx +: 10], sb[k].addr);
               end
            end
            sb.delete(k);
         end else if (sb[k].due < cyc) begin
            checks++;
            errors++;
            $display("FAIL %s: expectation missed its cycle", sb[k].name);
            sb.delete(k);
         end
      end
   end

   task automatic set_spr(input int i, input logic [9:0] x, input logic [9:0] y);
      spr_x[10*i +: 10] = x;
      spr_y[10*i +: 10] = y;
   endtask

   // Expect spr_addr of sprite idx after the edge that samples the next drive
   task automatic chk_addr(input int idx, input logic [9:0] a, input string nm);
      exp_t e;
      e.due = cyc + 1; e.kind = 1'b1; e.idx = idx; e.addr = a; e.name = nm;
      e.pix = '0; e.act = 1'b0; e.fs = 1'b0; e.coll = '0;
      sb.push_back(e);
   endtask

   // Drive one h/v sample and expect its composited result three cycles later
   task automatic drive(input logic [9:0] h, input logic [9:0] v, input logic [8:0] bg,
                        input logic [8:0] ep, input logic ea, input logic ef,
                        input logic [7:0] ec, input string nm);
      exp_t e;
      h_count  = h;
      v_count  = v;
      bg_color = bg;
      e.due = cyc + 3; e.kind = 1'b0; e.idx = 0; e.addr = '0; e.name = nm;
      e.pix = ep; e.act = ea; e.fs = ef; e.coll = ec;
      sb.push_back(e);
      @(negedge CLK);
   endtask

   task automatic idle(input logic [7:0] ec);
      drive(10'd700, 10'd10, 9'h000, 9'h000, 1'b0, 1'b0, ec, "idle");
   endtask

   initial begin
      checks = 0;
      errors = 0;
      RST_N = 1'b0;
      h_count = '0; v_count = '0; bg_color = 9'h007;
      spr_x = '0; spr_y = '0; spr_en = '0; spr_mirror = '0;
      for (int i = 0; i < NS; i++) rom_val[i] = 9'h000;
      @(negedge CLK);

      // Reset holds everything at zero
      chk_addr(0, 10'd0, "rst_addr");
      drive(10'd0, 10'd0, 9'h007, 9'h000, 1'b0, 1'b0, 8'h00, "rst0");
      drive(10'd0, 10'd0, 9'h007, 9'h000, 1'b0, 1'b0, 8'h00, "rst1");
      drive(10'd5, 10'd5, 9'h007, 9'h000, 1'b0, 1'b0, 8'h00, "rst2");
      RST_N = 1'b1;

      // Single sprite 2 at (100,50), edges and address generation
      spr_en = 8'b0000_0100; set_spr(2, 10'd100, 10'd50); rom_val[2] = 9'h1C0;
      chk_addr(2, 10'd0, "addr_s2_origin");
      drive(10'd100, 10'd50, 9'h007, 9'h1C0, 1'b1, 1'b0, 8'h00, "s2_hit");
      drive(10'd99,  10'd50, 9'h007, 9'h007, 1'b1, 1'b0, 8'h00, "s2_left_miss");
      chk_addr(2, 10'd31, "addr_s2_right");
      drive(10'd131, 10'd50, 9'h007, 9'h1C0, 1'b1, 1'b0, 8'h00, "s2_right_edge");
      chk_addr(2, 10'd31, "addr_s2_hold");
      drive(10'd132, 10'd50, 9'h007, 9'h007, 1'b1, 1'b0, 8'h00, "s2_right_miss");
      chk_addr(2, 10'd992, "addr_s2_bottom");
      drive(10'd100, 10'd81, 9'h007, 9'h1C0, 1'b1, 1'b0, 8'h00, "s2_bottom_edge");
      drive(10'd100, 10'd82, 9'h007, 9'h007, 1'b1, 1'b0, 8'h00, "s2_bottom_miss");
      drive(10'd100, 10'd49, 9'h007, 9'h007, 1'b1, 1'b0, 8'h00, "s2_top_miss");

      // Frame start pulse on pixel (0,0) only
      drive(10'd0, 10'd0, 9'h0AA, 9'h0AA, 1'b1, 1'b1, 8'h00, "frame00");
      drive(10'd1, 10'd0, 9'h0AA, 9'h0AA, 1'b1, 1'b0, 8'h00, "frame10");

      // Sprites 0 and 3 overlap: sprite 0 wins, collision bit 3
      spr_en = 8'b0000_1001; set_spr(0, 10'd200, 10'd200); set_spr(3, 10'd200, 10'd200);
      rom_val[0] = 9'h038; rom_val[3] = 9'h1FF;
      drive(10'd200, 10'd200, 9'h007, 9'h038, 1'b1, 1'b0, 8'h08, "ovl_hit");
      drive(10'd210, 10'd205, 9'h007, 9'h038, 1'b1, 1'b0, 8'h08, "ovl_inner");
      drive(10'd199, 10'd200, 9'h007, 9'h007, 1'b1, 1'b0, 8'h08, "ovl_sticky");

      // Collision on (0,0): clear of bit 3 and set of bit 5 in one cycle
      spr_en = 8'b0010_0001; set_spr(0, 10'd0, 10'd0); set_spr(5, 10'd0, 10'd0);
      rom_val[5] = 9'h041;
      drive(10'd0, 10'd0, 9'h007, 9'h038, 1'b1, 1'b1, 8'h20, "coll_at_00");
      drive(10'd1, 10'd0, 9'h007, 9'h038, 1'b1, 1'b0, 8'h20, "coll_after_00");
      idle(8'h20); idle(8'h20); idle(8'h20);

      // Transparent sprite 0 lets sprite 5 through without a collision
      rom_val[0] = 9'h000;
      drive(10'd5, 10'd5, 9'h007, 9'h041, 1'b1, 1'b0, 8'h20, "transparent0");
      idle(8'h20); idle(8'h20); idle(8'h20);

      // Plain frame start clears the sticky mask
      spr_en = 8'b0000_0000;
      drive(10'd0, 10'd0, 9'h007, 9'h007, 1'b1, 1'b1, 8'h00, "coll_clear");

      // Horizontal mirror on sprite 1
      spr_en = 8'b0000_0010; set_spr(1, 10'd10, 10'd20); spr_mirror = 8'b0000_0010;
      rom_val[1] = 9'h0F0;
      chk_addr(1, 10'd31, "mirror_addr0");
      drive(10'd10, 10'd20, 9'h007, 9'h0F0, 1'b1, 1'b0, 8'h00, "mirror_pix0");
      chk_addr(1, 10'd62, "mirror_addr1");
      drive(10'd11, 10'd21, 9'h007, 9'h0F0, 1'b1, 1'b0, 8'h00, "mirror_pix1");
      spr_mirror = 8'b0000_0000;
      chk_addr(1, 10'd0, "plain_addr0");
      drive(10'd10, 10'd20, 9'h007, 9'h0F0, 1'b1, 1'b0, 8'h00, "plain_pix0");
      chk_addr(1, 10'd33, "plain_addr1");
      drive(10'd11, 10'd21, 9'h007, 9'h0F0, 1'b1, 1'b0, 8'h00, "plain_pix1");

      // Right-edge sprite must not wrap to column 0
      spr_en = 8'b0001_0000; set_spr(4, 10'd1020, 10'd100); rom_val[4] = 9'h111;
      chk_addr(4, 10'd3, "wrap_hit_addr");
      drive(10'd1023, 10'd100, 9'h007, 9'h000, 1'b0, 1'b0, 8'h00, "wrap_hit_blank");
      chk_addr(4, 10'd3, "nowrap_hold");
      drive(10'd3, 10'd100, 9'h007, 9'h007, 1'b1, 1'b0, 8'h00, "nowrap_bg");

      // Blanking outside the active area even under an opaque sprite
      spr_en = 8'b0100_0000; set_spr(6, 10'd630, 10'd470); rom_val[6] = 9'h1FF;
      drive(10'd640, 10'd475, 9'h007, 9'h000, 1'b0, 1'b0, 8'h00, "blank_h640");
      drive(10'd639, 10'd475, 9'h007, 9'h1FF, 1'b1, 1'b0, 8'h00, "active_h639");
      drive(10'd635, 10'd480, 9'h007, 9'h000, 1'b0, 1'b0, 8'h00, "blank_v480");
      drive(10'd635, 10'd479, 9'h007, 9'h1FF, 1'b1, 1'b0, 8'h00, "active_v479");

      // One-cycle reset mid-line discards in-flight pixels and collisions
      spr_en = 8'b0000_0101; set_spr(0, 10'd300, 10'd100); set_spr(2, 10'd300, 10'd100);
      rom_val[0] = 9'h038;
      drive(10'd300, 10'd100, 9'h007, 9'h038, 1'b1, 1'b0, 8'h04, "pre_rst0");
      drive(10'd301, 10'd100, 9'h007, 9'h038, 1'b1, 1'b0, 8'h04, "pre_rst1");
      drive(10'd302, 10'd100, 9'h007, 9'h000, 1'b0, 1'b0, 8'h00, "rst_flush0");
      drive(10'd303, 10'd100, 9'h007, 9'h000, 1'b0, 1'b0, 8'h00, "rst_flush1");
      RST_N = 1'b0;
      chk_addr(0, 10'd0, "rst_mid_addr");
      drive(10'd304, 10'd100, 9'h007, 9'h000, 1'b0, 1'b0, 8'h00, "rst_flush2");
      RST_N = 1'b1;
      drive(10'd305, 10'd100, 9'h007, 9'h038, 1'b1, 1'b0, 8'h04, "post_rst0");
      drive(10'd306, 10'd100, 9'h007, 9'h038, 1'b1, 1'b0, 8'h04, "post_rst1");
      idle(8'h04); idle(8'h04); idle(8'h04); idle(8'h04);

      // Drain: anything left was never compared
      repeat (5) @(negedge CLK);
      while (sb.size() > 0) begin
         checks++;
         errors++;
         $display("FAIL %s: expectation never reached", sb[0].name);
         void'(sb.pop_front());
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
